// File: rtl/register_pipe_pkg.sv
// Shared definitions for the elastic register pipeline.
// Build option: define REGISTER_PIPE_FLUSH_EN to add the synchronous flush port.
package register_pipe_pkg;

    // Stage occupancy: number of words held in a 2-entry skid stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/register_pipe_stage.sv
// One 2-entry skid-buffer stage: main register feeds downstream, skid register absorbs overflow.
// Honours REGISTER_PIPE_FLUSH_EN (adds i_flush, which empties the stage and drops any accept).
module register_pipe_stage
    import register_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
`ifdef REGISTER_PIPE_FLUSH_EN
    input  logic             i_flush,
`endif
    input  logic             i_up_valid,
    output logic             o_up_ready,
    input  logic [WIDTH-1:0] i_up_data,
    output logic             o_dn_valid,
    input  logic             i_dn_ready,
    output logic [WIDTH-1:0] o_dn_data
);

    stage_state_e     r_state;
    logic             r_ready_up;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    stage_state_e     w_next_state;
    logic             w_accept;
    logic             w_send;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_accept         = i_up_valid && r_ready_up;
        w_send           = (r_state != ST_EMPTY) && i_dn_ready;

        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state = ST_BUSY;
                    w_load_main  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_accept && w_send) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ST_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_send) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Upstream sees ready low here, so only the send side can move.
                if (w_send) begin
                    w_next_state     = ST_BUSY;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase

`ifdef REGISTER_PIPE_FLUSH_EN
        if (i_flush) begin
            w_next_state     = ST_EMPTY;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_ready_up <= 1'b1;
            // NOTE: data registers are reset because out_data must read 0 before any word is held.
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_next_state;
            r_ready_up <= (w_next_state != ST_FULL);
            if (w_load_main) begin
                r_main <= i_up_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_up_data;
            end
        end
    end

    assign o_up_ready = r_ready_up;
    assign o_dn_valid = (r_state != ST_EMPTY);
    assign o_dn_data  = r_main;

endmodule

// File: rtl/register_pipe.sv
// Elastic WIDTH-bit register pipeline of DEPTH skid-buffer stages with valid/ready handshake.
// Define REGISTER_PIPE_FLUSH_EN to add the synchronous flush input.
module register_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
`ifdef REGISTER_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH < 1) begin : g_depth_err
        $error("register_pipe: DEPTH must be >= 1");
    end

    // Index i is the interface feeding stage i; index DEPTH is the pipeline output.
    logic [DEPTH:0]   w_valid;
    logic [DEPTH:0]   w_ready;
    logic [WIDTH-1:0] w_data [DEPTH+1];

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign in_ready       = w_ready[0];
    assign out_valid      = w_valid[DEPTH];
    assign out_data       = w_data[DEPTH];
    assign w_ready[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        register_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
`ifdef REGISTER_PIPE_FLUSH_EN
            .i_flush    (flush),
`endif
            .i_up_valid (w_valid[i]),
            .o_up_ready (w_ready[i]),
            .i_up_data  (w_data[i]),
            .o_dn_valid (w_valid[i+1]),
            .i_dn_ready (w_ready[i+1]),
            .o_dn_data  (w_data[i+1])
        );
    end

endmodule

// File: tb/tb_register_pipe.sv
// Self-checking bench for register_pipe (WIDTH=8, DEPTH=3): queue-based scoreboard plus directed literals.
// Exercises the flush scenario only when REGISTER_PIPE_FLUSH_EN is defined.
module tb_register_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CAP   = 2 * DEPTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef REGISTER_PIPE_FLUSH_EN
    logic             flush;
`endif

    register_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef REGISTER_PIPE_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               e;
    } word_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: words in flight in FIFO order, tagged with their accept edge.
    word_t            q[$];
    logic [WIDTH-1:0] pop_data[$];
    int               pop_cyc[$];
    int               acc_cyc[$];
    int               cyc = 0;
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are stable at the falling edge; the handshakes seen here
    // are the transfers the next rising edge performs.
    always @(negedge clk) begin
        logic flushing;
        flushing = 1'b0;
`ifdef REGISTER_PIPE_FLUSH_EN
        flushing = flush;
`endif
        if (!reset) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data",  32'(out_data),  32'd0);
            check("rst_in_ready",  32'(in_ready),  32'd1);
            q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data",  32'(out_data),  32'(prev_data));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("out_data", 32'(out_data), 32'(q[0].d));
                    check("latency_min", 32'(cyc >= q[0].e + DEPTH), 32'd1);
                end
            end
            if (q.size() == 0)   check("empty_in_ready", 32'(in_ready), 32'd1);
            if (q.size() == CAP) check("full_in_ready",  32'(in_ready), 32'd0);

            if (flushing) begin
                q.delete();
                prev_hold = 1'b0;
            end else begin
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
                if (out_valid && out_ready && q.size() != 0) begin
                    pop_data.push_back(out_data);
                    pop_cyc.push_back(cyc);
                    void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
                    q.push_back('{d: in_data, e: cyc});
                    acc_cyc.push_back(cyc);
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        pop_data.delete();
        pop_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        tick();
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef REGISTER_PIPE_FLUSH_EN
        flush     = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b1;

        // 1: constant word, free-flowing output.
        clear_logs();
        in_valid  = 1'b1;
        in_data   = 8'hAB;
        out_ready = 1'b1;
        repeat (12) tick();
        drain("t1_drain");
        if (pop_cyc.size() >= 10 && acc_cyc.size() >= 1) begin
            check("t1_latency", 32'(pop_cyc[0] - acc_cyc[0]), 32'd3);
            check("t1_data", 32'(pop_data[9]), 32'hAB);
            check("t1_no_loss", 32'(pop_data.size()), 32'(acc_cyc.size()));
        end else begin
            check("t1_outputs", 32'(pop_cyc.size()), 32'd12);
        end

        // 2: back-to-back stream 0x00..0x0F, no gaps, fixed latency.
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        drain("t2_drain");
        check("t2_count", 32'(pop_data.size()), 32'd16);
        if (pop_data.size() == 16 && acc_cyc.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("t2_data", 32'(pop_data[i]), 32'(i));
                check("t2_latency", 32'(pop_cyc[i] - acc_cyc[i]), 32'd3);
                if (i > 0) check("t2_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
            end
        end

        // 3: stalled output fills exactly 2*DEPTH words, then drains in order.
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h30 + i);
            tick();
        end
        check("t3_accepted", 32'(acc_cyc.size()), 32'd6);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        check("t3_out_valid", 32'(out_valid), 32'd1);
        check("t3_out_held", 32'(out_data), 32'h30);
        drain("t3_drain");
        check("t3_count", 32'(pop_data.size()), 32'd6);
        if (pop_data.size() == 6) begin
            for (int i = 0; i < 6; i++) check("t3_order", 32'(pop_data[i]), 32'(8'h30 + i));
        end

        // 4: random valid/ready at 50% against the scoreboard.
        clear_logs();
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain("t4_drain");
        check("t4_no_loss", 32'(pop_data.size()), 32'(acc_cyc.size()));

        // 5: asynchronous reset with 4 words buffered.
        clear_logs();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h40 + i);
            tick();
        end
        in_valid = 1'b0;
        check("t5_buffered", 32'(acc_cyc.size()), 32'd4);
        #1 reset = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_data",  32'(out_data),  32'd0);
        check("t5_async_ready", 32'(in_ready),  32'd1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("t5_ready_after", 32'(in_ready), 32'd1);
        clear_logs();
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(8'h80, 8'hFF));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain("t5_drain");
        check("t5_no_stale", 32'(pop_data.size()), 32'(acc_cyc.size()));

`ifdef REGISTER_PIPE_FLUSH_EN
        // 6: flush with a full pipe, then with a partly filled pipe while a word is accepted.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h50 + i);
            tick();
        end
        in_data = 8'hEE;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t6_flush_valid", 32'(out_valid), 32'd0);
        check("t6_flush_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b1;
        in_data  = 8'h51;
        tick();
        in_data  = 8'hEE;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t6_flush2_valid", 32'(out_valid), 32'd0);
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h60 + i);
            tick();
        end
        drain("t6_drain");
        check("t6_count", 32'(pop_data.size()), 32'd4);
        if (pop_data.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t6_order", 32'(pop_data[i]), 32'(8'h60 + i));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
